// File: rtl/mux_rr_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_pipe
// Brief    : Registered N:1 valid/ready mux, fixed-index or round-robin select.
//            Optional packet lock for round-robin mode: MUX_RR_PKT_LOCK_EN.
// Revision : 1.0
// ============================================================================
module mux_rr_pipe #(
  parameter  int WIDTH    = 64,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
`ifdef MUX_RR_PKT_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
`endif
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SEL_W-1:0] c_RR_INIT = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_ch;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_load_en;
  logic             w_xfer;
  logic [SEL_W-1:0] w_grant;
  logic             w_granted;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_rr_found;
  logic [WIDTH-1:0] w_sel_data;
  int               w_rr_dist;
  int               w_rr_best;

`ifdef MUX_RR_PKT_LOCK_EN
  logic             r_lock;
  logic [SEL_W-1:0] r_lock_idx;
  logic             w_lock_valid;
  logic             w_last;
`endif

  assign w_load_en = !r_out_valid || out_ready;
  assign w_xfer    = w_load_en && w_granted;

  // Pick the valid channel closest after r_rr_ptr, measured modulo CHANNELS.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_rr_best  = CHANNELS;
    w_rr_dist  = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_rr_dist = (i + 2 * CHANNELS - int'(r_rr_ptr) - 1) % CHANNELS;
      if (in_valid[i] && (w_rr_dist < w_rr_best)) begin
        w_rr_best  = w_rr_dist;
        w_rr_idx   = SEL_W'(i);
        w_rr_found = 1'b1;
      end
    end
  end

`ifdef MUX_RR_PKT_LOCK_EN
  always_comb begin
    w_lock_valid = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_lock_idx == SEL_W'(i)) w_lock_valid = in_valid[i];
    end
  end
`endif

  // An out-of-range sel matches no channel, so nothing is granted.
  always_comb begin
    w_grant   = '0;
    w_granted = 1'b0;
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if ((sel == SEL_W'(i)) && in_valid[i]) begin
          w_grant   = sel;
          w_granted = 1'b1;
        end
      end
    end
`ifdef MUX_RR_PKT_LOCK_EN
    else if (r_lock) begin
      w_grant   = r_lock_idx;
      w_granted = w_lock_valid;
    end
`endif
    else begin
      w_grant   = w_rr_idx;
      w_granted = w_rr_found;
    end
  end

`ifdef MUX_RR_PKT_LOCK_EN
  always_comb begin
    w_last = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant == SEL_W'(i)) w_last = in_last[i];
    end
  end
`endif

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant == SEL_W'(i)) w_sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // rst_n gates ready so nothing is accepted while reset is held.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = rst_n && w_xfer && (w_grant == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= c_RR_INIT;
`ifdef MUX_RR_PKT_LOCK_EN
      r_lock      <= 1'b0;
      r_lock_idx  <= '0;
`endif
    end else begin
      if (w_load_en) begin
        r_out_valid <= w_granted;
        if (w_granted) begin
          r_out_data <= w_sel_data;
          r_out_ch   <= w_grant;
        end
      end
`ifdef MUX_RR_PKT_LOCK_EN
      if (!mode) begin
        r_lock <= 1'b0;
      end else if (w_xfer) begin
        r_lock     <= !w_last;
        r_lock_idx <= w_grant;
        if (w_last) r_rr_ptr <= w_grant;
      end
`else
      if (mode && w_xfer) r_rr_ptr <= w_grant;
`endif
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire
